// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared state encoding, command/result records and constants
// for the FPU operation sequencer (records are sized at the default widths).
package fpu_seq_pkg;

  localparam int SEQ_DATA_W = 32;
  localparam int SEQ_OP_W   = 8;
  localparam int SEQ_RM_W   = 2;
  localparam int SEQ_CSR_W  = 12;

  // Opcode bit that marks a compare operation.
  localparam int CMP_BIT = 3;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXECUTE,
    WAIT,
    FLUSH,
    DRAIN,
    HOLD
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_OP_W-1:0]   op;
    logic [SEQ_RM_W-1:0]   rm;
    logic [SEQ_DATA_W-1:0] opa;
    logic [SEQ_DATA_W-1:0] opb;
  } cmd_t;

  typedef struct packed {
    logic [SEQ_DATA_W-1:0] data;
    logic                  cmp;
    logic [SEQ_CSR_W-1:0]  fpcsr;
    logic                  timeout;
  } res_t;

endpackage

// File: rtl/fpu_seq_fifo.sv
// fpu_seq_fifo: generic DEPTH-entry synchronous FIFO of element type T.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module fpu_seq_fifo
  import fpu_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T            mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // A pop frees the head slot in the same cycle, so a full FIFO may also take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: queues FPU commands and drives the decode/execute/flush handshake,
// returning one result record per op. Define FPU_SEQ_TIMEOUT_EN to bound WAIT and DRAIN.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int DATA_W  = SEQ_DATA_W,
  parameter int OP_W    = SEQ_OP_W,
  parameter int RM_W    = SEQ_RM_W,
  parameter int CSR_W   = SEQ_CSR_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RM_W-1:0]   cmd_rm,
  input  logic [DATA_W-1:0] cmd_opa,
  input  logic [DATA_W-1:0] cmd_opb,
  output logic              fpu_decode,
  output logic              fpu_execute,
  output logic              fpu_flush,
  output logic [OP_W-1:0]   fpu_op,
  output logic [RM_W-1:0]   fpu_rm,
  output logic [DATA_W-1:0] fpu_opa,
  output logic [DATA_W-1:0] fpu_opb,
  input  logic [DATA_W-1:0] fpu_out,
  input  logic              fpu_valid_arith,
  input  logic              fpu_valid_cmp,
  input  logic              fpu_cmp,
  input  logic [CSR_W-1:0]  fpu_fpcsr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cmp,
  output logic [CSR_W-1:0]  res_fpcsr,
  output logic              res_timeout,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RM_W-1:0]   rm;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } issue_t;

  if (TIMEOUT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("fpu_op_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  seq_state_t        state_q;
  seq_state_t        state_d;
  issue_t            issue_q;
  issue_t            cmd_in;
  issue_t            fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              cmd_fire;
  logic              bypass;
  logic              op_is_cmp;
  logic              op_done;
  logic              wait_expired;
  logic              timeout_fire;
  logic [DATA_W-1:0] res_data_q;
  logic              res_cmp_q;
  logic [CSR_W-1:0]  res_fpcsr_q;
  logic [15:0]       done_cnt_q;

  assign cmd_in    = {cmd_op, cmd_rm, cmd_opa, cmd_opb};
  assign cmd_ready = !fifo_full;
  assign cmd_fire  = cmd_valid && !fifo_full;

  // An idle, empty sequencer loads the offered command straight into the issue register.
  assign bypass    = (state_q == IDLE) && fifo_empty && cmd_fire;
  assign fifo_push = cmd_fire && !bypass;

  fpu_seq_fifo #(
    .DEPTH (DEPTH),
    .T     (issue_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (cmd_in),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign op_is_cmp    = issue_q.op[CMP_BIT];
  assign op_done      = (state_q == WAIT) && (op_is_cmp ? fpu_valid_cmp : fpu_valid_arith);
  assign timeout_fire = wait_expired && !op_done && ((state_q == WAIT) || (fpu_out != '0));

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // The counter restarts for WAIT and again for DRAIN, giving each its own budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == EXECUTE || state_q == FLUSH) begin
        wait_cnt_q <= '0;
      end else if ((state_q == WAIT || state_q == DRAIN) && !wait_expired) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (op_done) begin
        timeout_q <= 1'b0;
      end else if (timeout_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign wait_expired = (state_q == WAIT || state_q == DRAIN) &&
                        (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  assign res_timeout  = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign res_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DECODE;
        end else if (cmd_fire) begin
          state_d = DECODE;
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = WAIT;
      WAIT: begin
        if (op_done || timeout_fire) state_d = FLUSH;
      end
      FLUSH: state_d = DRAIN;
      DRAIN: begin
        if (fpu_out == '0 || timeout_fire) state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = DECODE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue register, result capture and completion counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_q     <= '0;
      res_data_q  <= '0;
      res_cmp_q   <= 1'b0;
      res_fpcsr_q <= '0;
      done_cnt_q  <= '0;
    end else begin
      if (fifo_pop) begin
        issue_q <= fifo_rdata;
      end else if (bypass) begin
        issue_q <= cmd_in;
      end
      if (op_done) begin
        res_data_q  <= op_is_cmp ? '0 : fpu_out;
        res_cmp_q   <= op_is_cmp && fpu_cmp;
        res_fpcsr_q <= fpu_fpcsr;
      end else if (timeout_fire) begin
        res_data_q  <= '0;
        res_cmp_q   <= 1'b0;
        res_fpcsr_q <= '0;
      end
      if (state_q == HOLD && res_ready) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign fpu_decode  = (state_q == DECODE);
  assign fpu_execute = (state_q == EXECUTE);
  assign fpu_flush   = (state_q == FLUSH);
  assign fpu_op      = issue_q.op;
  assign fpu_rm      = issue_q.rm;
  assign fpu_opa     = issue_q.opa;
  assign fpu_opb     = issue_q.opb;
  assign res_valid   = (state_q == HOLD);
  assign res_data    = res_data_q;
  assign res_cmp     = res_cmp_q;
  assign res_fpcsr   = res_fpcsr_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed self-checking bench; the FPU is stubbed inline.
// The timeout steps are compiled only when FPU_SEQ_TIMEOUT_EN is defined.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [1:0]  cmd_rm;
  logic [31:0] cmd_opa;
  logic [31:0] cmd_opb;
  logic        fpu_decode;
  logic        fpu_execute;
  logic        fpu_flush;
  logic [7:0]  fpu_op;
  logic [1:0]  fpu_rm;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [31:0] fpu_out;
  logic        fpu_valid_arith;
  logic        fpu_valid_cmp;
  logic        fpu_cmp;
  logic [11:0] fpu_fpcsr;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_cmp;
  logic [11:0] res_fpcsr;
  logic        res_timeout;
  logic        busy;
  logic [15:0] done_cnt;

  int tests    = 0;
  int failures = 0;

  fpu_op_sequencer #(
    .DATA_W  (32),
    .OP_W    (8),
    .RM_W    (2),
    .CSR_W   (12),
    .DEPTH   (4),
    .TIMEOUT (64)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_rm          (cmd_rm),
    .cmd_opa         (cmd_opa),
    .cmd_opb         (cmd_opb),
    .fpu_decode      (fpu_decode),
    .fpu_execute     (fpu_execute),
    .fpu_flush       (fpu_flush),
    .fpu_op          (fpu_op),
    .fpu_rm          (fpu_rm),
    .fpu_opa         (fpu_opa),
    .fpu_opb         (fpu_opb),
    .fpu_out         (fpu_out),
    .fpu_valid_arith (fpu_valid_arith),
    .fpu_valid_cmp   (fpu_valid_cmp),
    .fpu_cmp         (fpu_cmp),
    .fpu_fpcsr       (fpu_fpcsr),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_cmp         (res_cmp),
    .res_fpcsr       (res_fpcsr),
    .res_timeout     (res_timeout),
    .busy            (busy),
    .done_cnt        (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] opa, input logic [31:0] opb);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rm    = 2'd1;
    cmd_opa   = opa;
    cmd_opb   = opb;
  endtask

  // Waits (bounded) for execute, completes the arith op in its first WAIT cycle, drains in one cycle.
  task automatic serviceOp(input string tag, input logic [31:0] exp_opa, input logic [31:0] result);
    int n = 0;
    while (fpu_execute !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " execute"}, 32'(fpu_execute), 32'd1);
    checkOutput({tag, " opa"}, fpu_opa, exp_opa);
    tick();
    fpu_valid_arith = 1'b1;
    fpu_out         = result;
    tick();
    checkOutput({tag, " flush"}, 32'(fpu_flush), 32'd1);
    fpu_valid_arith = 1'b0;
    fpu_out         = 32'd0;
    tick();
    tick();
    checkOutput({tag, " res_valid"}, 32'(res_valid), 32'd1);
    checkOutput({tag, " res_data"}, res_data, result);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b1;
    cmd_valid       = 1'b0;
    cmd_op          = 8'd0;
    cmd_rm          = 2'd0;
    cmd_opa         = 32'd0;
    cmd_opb         = 32'd0;
    fpu_out         = 32'd0;
    fpu_valid_arith = 1'b0;
    fpu_valid_cmp   = 1'b0;
    fpu_cmp         = 1'b0;
    fpu_fpcsr       = 12'd0;
    res_ready       = 1'b0;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset decode", 32'(fpu_decode), 32'd0);
    checkOutput("reset done_cnt", 32'(done_cnt), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Arithmetic op, valid 3 cycles after execute
    applyStimulus(8'h00, 32'h3F800000, 32'h40000000);
    tick();
    cmd_valid = 1'b0;
    checkOutput("arith decode", 32'(fpu_decode), 32'd1);
    checkOutput("arith execute early", 32'(fpu_execute), 32'd0);
    checkOutput("arith fpu_opa", fpu_opa, 32'h3F800000);
    checkOutput("arith fpu_opb", fpu_opb, 32'h40000000);
    checkOutput("arith fpu_rm", 32'(fpu_rm), 32'd1);
    tick();
    checkOutput("arith execute", 32'(fpu_execute), 32'd1);
    checkOutput("arith decode drop", 32'(fpu_decode), 32'd0);
    tick();
    checkOutput("arith wait busy", 32'(busy), 32'd1);
    checkOutput("arith no early flush", 32'(fpu_flush), 32'd0);
    tick();
    tick();
    fpu_valid_arith = 1'b1;
    fpu_out         = 32'h40400000;
    fpu_fpcsr       = 12'h005;
    tick();
    checkOutput("arith flush", 32'(fpu_flush), 32'd1);
    fpu_valid_arith = 1'b0;
    fpu_out         = 32'd0;
    fpu_fpcsr       = 12'd0;
    tick();
    checkOutput("arith drain no res", 32'(res_valid), 32'd0);
    checkOutput("arith opa stable", fpu_opa, 32'h3F800000);
    tick();
    checkOutput("arith res_valid", 32'(res_valid), 32'd1);
    checkOutput("arith res_data", res_data, 32'h40400000);
    checkOutput("arith res_cmp", 32'(res_cmp), 32'd0);
    checkOutput("arith res_fpcsr", 32'(res_fpcsr), 32'h005);
    checkOutput("arith res_timeout", 32'(res_timeout), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("arith done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("arith idle busy", 32'(busy), 32'd0);

    // Compare op ignores valid_arith
    applyStimulus(8'h08, 32'h3F800000, 32'h3F800000);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    fpu_valid_arith = 1'b1;
    fpu_out         = 32'hDEAD0000;
    tick();
    checkOutput("cmp ignores arith valid", 32'(fpu_flush), 32'd0);
    fpu_valid_arith = 1'b0;
    fpu_valid_cmp   = 1'b1;
    fpu_cmp         = 1'b1;
    fpu_fpcsr       = 12'h010;
    tick();
    checkOutput("cmp flush", 32'(fpu_flush), 32'd1);
    fpu_valid_cmp = 1'b0;
    fpu_cmp       = 1'b0;
    fpu_out       = 32'd0;
    fpu_fpcsr     = 12'd0;
    tick();
    tick();
    checkOutput("cmp res_valid", 32'(res_valid), 32'd1);
    checkOutput("cmp res_cmp", 32'(res_cmp), 32'd1);
    checkOutput("cmp res_data", res_data, 32'd0);
    checkOutput("cmp res_fpcsr", 32'(res_fpcsr), 32'h010);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("cmp done_cnt", 32'(done_cnt), 32'd2);

    // Drain holds off the result while fpu_out is non-zero
    applyStimulus(8'h00, 32'h11111111, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    fpu_valid_arith = 1'b1;
    fpu_out         = 32'h00000055;
    tick();
    checkOutput("drain flush", 32'(fpu_flush), 32'd1);
    fpu_valid_arith = 1'b0;
    fpu_out         = 32'h00001234;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("drain hold-off", 32'(res_valid), 32'd0);
      tick();
    end
    fpu_out = 32'd0;
    checkOutput("drain last cycle", 32'(res_valid), 32'd0);
    tick();
    checkOutput("drain res_valid", 32'(res_valid), 32'd1);
    checkOutput("drain res_data", res_data, 32'h00000055);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("drain done_cnt", 32'(done_cnt), 32'd3);

    // Backpressure: one op in flight plus four queued, sixth offer refused
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'h00, 32'h100 + 32'(k), 32'd0);
      checkOutput("fill cmd_ready", 32'(cmd_ready), (k < 5) ? 32'd1 : 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    checkOutput("full cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("full busy", 32'(busy), 32'd1);
    checkOutput("full first opa", fpu_opa, 32'h100);
    fpu_valid_arith = 1'b1;
    fpu_out         = 32'h000000A0;
    tick();
    fpu_valid_arith = 1'b0;
    fpu_out         = 32'd0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp res_valid held", 32'(res_valid), 32'd1);
      checkOutput("bp res_data held", res_data, 32'h000000A0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("bp next decode", 32'(fpu_decode), 32'd1);
    checkOutput("bp next opa", fpu_opa, 32'h101);
    checkOutput("bp ready after pop", 32'(cmd_ready), 32'd1);
    for (int k = 1; k < 5; k++) begin
      serviceOp("order", 32'h100 + 32'(k), 32'hA0 + 32'(k));
    end
    checkOutput("bp done_cnt", 32'(done_cnt), 32'd8);
    checkOutput("bp idle busy", 32'(busy), 32'd0);

    // Reset in WAIT with two ops queued
    applyStimulus(8'h00, 32'h200, 32'd0);
    tick();
    applyStimulus(8'h00, 32'h201, 32'd0);
    tick();
    applyStimulus(8'h00, 32'h202, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset decode", 32'(fpu_decode), 32'd0);
    checkOutput("mid reset execute", 32'(fpu_execute), 32'd0);
    checkOutput("mid reset flush", 32'(fpu_flush), 32'd0);
    checkOutput("mid reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("mid reset fpu_opa", fpu_opa, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post reset res_valid", 32'(res_valid), 32'd0);
      checkOutput("post reset busy", 32'(busy), 32'd0);
      checkOutput("post reset decode", 32'(fpu_decode), 32'd0);
    end

`ifdef FPU_SEQ_TIMEOUT_EN
    // Timeout: no valid ever arrives, the queued op still issues afterwards
    applyStimulus(8'h00, 32'h300, 32'd0);
    tick();
    applyStimulus(8'h00, 32'h301, 32'd0);
    tick();
    cmd_valid = 1'b0;
    fpu_out   = 32'h77;
    tick();
    for (int i = 0; i < 63; i++) tick();
    checkOutput("timeout not yet", 32'(res_timeout), 32'd0);
    checkOutput("timeout no flush yet", 32'(fpu_flush), 32'd0);
    tick();
    checkOutput("timeout flag", 32'(res_timeout), 32'd1);
    checkOutput("timeout flush", 32'(fpu_flush), 32'd1);
    fpu_out = 32'd0;
    tick();
    tick();
    checkOutput("timeout res_valid", 32'(res_valid), 32'd1);
    checkOutput("timeout res_data", res_data, 32'd0);
    checkOutput("timeout res_timeout", 32'(res_timeout), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("timeout next decode", 32'(fpu_decode), 32'd1);
    serviceOp("after timeout", 32'h301, 32'h88);
    checkOutput("after timeout flag clear", 32'(res_timeout), 32'd0);
    checkOutput("timeout done_cnt", 32'(done_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
